disp_chan_mux: RTL

- Parameterised successor to the single-source seven-segment data selector.
- Holds the latest sample from NCH value channels (fps, Sobel threshold, debug counters, and similar).
- Picks one channel by manual select, timed auto-rotation or freeze.
- Clamps and signs the value for a 6-digit display and drives the segment driver's data/point/sign/enable inputs.

---
 rtl/disp_pkg.sv | 27 ++
 rtl/disp_sat_conv.sv | 28 ++
 rtl/disp_chan_mux.sv | 114 +++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared encodings and display limits for the display channel multiplexer.
package disp_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_FREEZE = 2'd2;

  localparam int DISP_MAX     = 999999;
  localparam int DISP_MAX_NEG = 99999;
  localparam int DISP_DIGITS  = 6;

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_AUTO,
    ST_FREEZE
  } chan_state_t;

  // Mode 3 is unused and behaves exactly like freeze.
  function automatic chan_state_t decode_mode(input logic [1:0] m);
    case (m)
      MODE_MANUAL: return ST_MANUAL;
      MODE_AUTO:   return ST_AUTO;
      default:     return ST_FREEZE;
    endcase
  endfunction

endpackage

// File: rtl/disp_sat_conv.sv
// Converts a raw channel value into a clamped display magnitude plus minus flag.
module disp_sat_conv
  import disp_pkg::*;
#(
  parameter int DW = 20
) (
  input  logic [DW-1:0] value,
  input  logic          is_signed,
  output logic [19:0]   mag,
  output logic          neg
);

  // Two spare bits keep |most-negative| and the 20-bit limits representable.
  localparam int EW = ((DW > 20) ? DW : 20) + 2;

  logic [EW-1:0] ext;
  logic [EW-1:0] abs_val;
  logic [EW-1:0] limit;

  always_comb begin
    neg     = is_signed & value[DW-1];
    ext     = {{(EW-DW){neg}}, value};
    abs_val = neg ? (~ext + EW'(1)) : ext;
    limit   = neg ? EW'(DISP_MAX_NEG) : EW'(DISP_MAX);
    mag     = (abs_val > limit) ? limit[19:0] : abs_val[19:0];
  end

endmodule

// File: rtl/disp_chan_mux.sv
// Multi-channel value selector for the 6-digit seven-segment driver:
// shadows each channel, picks one (manual / auto-rotate / freeze) and clamps it.
module disp_chan_mux
  import disp_pkg::*;
#(
  parameter int                 NCH         = 4,
  parameter int                 DW          = 20,
  parameter int                 DWELL       = 50_000_000,
  parameter logic [NCH-1:0]     SIGNED_MASK = '0,
  parameter logic [NCH*6-1:0]   POINT_CFG   = '0,
  localparam int                CW          = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*DW-1:0]      ch_data,
  input  logic [NCH-1:0]         ch_vld,
  input  logic [1:0]             mode,
  input  logic [CW-1:0]          sel,
  input  logic                   step,
  output logic [19:0]            data,
  output logic [DISP_DIGITS-1:0] point,
  output logic                   sign,
  output logic                   en,
  output logic [CW-1:0]          cur_ch,
  output logic                   upd
);

  localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [CW-1:0]   CH_LAST  = CW'(NCH - 1);

  logic [DW-1:0]          shadow [NCH];
  chan_state_t            state;
  chan_state_t            state_nxt;
  logic [CNTW-1:0]        cnt;
  logic [CNTW-1:0]        cnt_eff;
  logic [CW-1:0]          prev_ch;
  logic [CW-1:0]          ch_inc;
  logic [19:0]            conv_mag;
  logic                   conv_neg;
  logic [DISP_DIGITS-1:0] conv_pt;

  // The dwell count only survives while staying in AUTO; any entry restarts it.
  always_comb begin
    state_nxt = decode_mode(mode);
    ch_inc    = (cur_ch == CH_LAST) ? '0 : cur_ch + CW'(1);
    cnt_eff   = (state == ST_AUTO) ? cnt : '0;
    conv_pt   = POINT_CFG[cur_ch*DISP_DIGITS +: DISP_DIGITS];
  end

  disp_sat_conv #(
    .DW(DW)
  ) u_conv (
    .value     (shadow[cur_ch]),
    .is_signed (SIGNED_MASK[cur_ch]),
    .mag       (conv_mag),
    .neg       (conv_neg)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst)
        shadow[i] <= '0;
      else if (ch_vld[i])
        shadow[i] <= ch_data[i*DW +: DW];
    end
  end

  // en drops for the cycle after cur_ch moves, by comparing against last cycle's channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_MANUAL;
      cur_ch  <= '0;
      prev_ch <= '0;
      cnt     <= '0;
      data    <= '0;
      point   <= '0;
      sign    <= 1'b0;
      en      <= 1'b0;
      upd     <= 1'b0;
    end else begin
      state   <= state_nxt;
      prev_ch <= cur_ch;
      en      <= (prev_ch == cur_ch);
      upd     <= 1'b0;
      case (state_nxt)
        ST_MANUAL: begin
          cnt <= '0;
          if (step)
            cur_ch <= ch_inc;
          else if (int'(sel) < NCH)
            cur_ch <= sel;
        end
        ST_AUTO: begin
          if (step || (cnt_eff == CNT_LAST)) begin
            cur_ch <= ch_inc;
            cnt    <= '0;
          end else begin
            cnt <= cnt_eff + CNTW'(1);
          end
        end
        default: begin
        end
      endcase
      if (state_nxt != ST_FREEZE) begin
        data  <= conv_mag;
        point <= conv_pt;
        sign  <= conv_neg;
        upd   <= (conv_mag != data) || (conv_pt != point) || (conv_neg != sign);
      end
    end
  end

endmodule
